// File: rtl/extend_arbiter.sv
// Round-robin arbiter sharing one zero/sign-extension unit among NUM_REQ requesters,
// with a single registered output stage. Optional stall statistic: EXTEND_ARBITER_STATS_EN.
module extend_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned DATA_WIDTH = 64,
  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*2-1:0]          req_size,
  input  logic [NUM_REQ-1:0]            req_signed,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [15:0]                   stall_count
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e                  state_q;
  logic [ID_W-1:0]         rr_ptr_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [ID_W-1:0]         out_id_q;

  logic                    can_accept;
  logic                    found;
  logic [ID_W-1:0]         cand;
  logic [ID_W-1:0]         win_id;
  logic [DATA_WIDTH-1:0]   sel_data;
  logic [1:0]              sel_size;
  logic                    sel_signed;
  logic                    transfer;

  function automatic logic [DATA_WIDTH-1:0] extend(input logic [DATA_WIDTH-1:0] d,
                                                   input logic [1:0]            sz,
                                                   input logic                  sg);
    logic [DATA_WIDTH-1:0] r;
    unique case (sz)
      2'b00:   r = {{(DATA_WIDTH-8){sg & d[7]}}, d[7:0]};
      2'b01:   r = {{(DATA_WIDTH-16){sg & d[15]}}, d[15:0]};
      2'b10:   r = {{(DATA_WIDTH-32){sg & d[31]}}, d[31:0]};
      default: r = d;
    endcase
    return r;
  endfunction

  assign out_valid  = (state_q == StFull);
  assign can_accept = !out_valid || out_ready;

  // Search begins one past the last winner and wraps, giving round-robin fairness.
  always_comb begin
    found  = 1'b0;
    cand   = '0;
    win_id = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  always_comb begin
    sel_data   = '0;
    sel_size   = '0;
    sel_signed = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == win_id) begin
        sel_data   = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_size   = req_size[i*2 +: 2];
        sel_signed = req_signed[i];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (found && can_accept && !reset) begin
      req_ready = NUM_REQ'(1) << win_id;
    end
  end

  assign transfer = |req_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StEmpty;
      rr_ptr_q   <= ID_W'(NUM_REQ - 1);
      out_data_q <= '0;
      out_id_q   <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (transfer) begin
            state_q    <= StFull;
            rr_ptr_q   <= win_id;
            out_data_q <= extend(sel_data, sel_size, sel_signed);
            out_id_q   <= win_id;
          end
        end
        StFull: begin
          if (transfer) begin
            rr_ptr_q   <= win_id;
            out_data_q <= extend(sel_data, sel_size, sel_signed);
            out_id_q   <= win_id;
          end else if (out_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign out_data = out_data_q;
  assign out_id   = out_id_q;

`ifdef EXTEND_ARBITER_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (out_valid && !out_ready && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_extend_arbiter.sv
// Self-checking bench for extend_arbiter (NUM_REQ=2, DATA_WIDTH=64): directed steps followed
// by constrained-random traffic checked against a behavioural model.
module tb_extend_arbiter;

  localparam int N  = 2;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*DW-1:0] req_data;
  logic [N*2-1:0]  req_size;
  logic [N-1:0]    req_signed;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [0:0]      out_id;
  logic [15:0]     stall_count;

  extend_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_size   (req_size),
    .req_signed (req_signed),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Stimulus arrays, packed onto the bus before each step.
  logic          v  [N];
  logic [DW-1:0] d  [N];
  logic [1:0]    sz [N];
  logic          sg [N];

  // Behavioural model state.
  int            m_ptr;
  logic          m_valid;
  logic [DW-1:0] m_data;
  int            m_id;
  int            m_stall;
  logic [N-1:0]  last_gnt;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_ext(input logic [DW-1:0] x, input logic [1:0] s,
                                             input logic sgn);
    int            w;
    logic [DW-1:0] mask;
    logic [DW-1:0] r;
    w    = (s == 2'd3) ? DW : (8 << s);
    mask = (w == DW) ? '1 : ((64'd1 << w) - 64'd1);
    r    = x & mask;
    if (w != DW && sgn && r[w-1]) r = r | ~mask;
    return r;
  endfunction

  function automatic int exp_stall();
`ifdef EXTEND_ARBITER_STATS_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  task automatic model_reset();
    m_ptr    = N - 1;
    m_valid  = 1'b0;
    m_data   = '0;
    m_id     = 0;
    m_stall  = 0;
    last_gnt = '0;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_data[i*DW +: DW]  = d[i];
      req_size[i*2 +: 2]    = sz[i];
      req_signed[i]         = sg[i];
    end
  endtask

  // Called just after a negedge: check arbitration, clock once, check registered state.
  task automatic step(input string tag);
    logic [N-1:0] exp_rdy;
    int           win;
    logic         can;
    drive();
    #1;
    win = -1;
    for (int k = 1; k <= N; k++) begin
      if (win < 0 && v[(m_ptr + k) % N]) win = (m_ptr + k) % N;
    end
    can     = !m_valid || out_ready;
    exp_rdy = '0;
    if (win >= 0 && can) exp_rdy[win] = 1'b1;
    check({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    if (m_valid && !out_ready && m_stall < 16'hFFFF) m_stall++;
    if (exp_rdy != '0) begin
      m_data  = ref_ext(d[win], sz[win], sg[win]);
      m_id    = win;
      m_ptr   = win;
      m_valid = 1'b1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    last_gnt = exp_rdy;
    #1;
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".data"},  out_data, m_data);
    check({tag, ".id"},    64'(out_id), 64'(m_id));
    check({tag, ".stall"}, 64'(stall_count), 64'(exp_stall()));
    @(negedge clk);
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    #1;
    model_reset();
    check("rst.valid", 64'(out_valid), 64'd0);
    check("rst.ready", 64'(req_ready), 64'd0);
    check("rst.data",  out_data, 64'd0);
    check("rst.stall", 64'(stall_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; d[i] = '0; sz[i] = 2'd0; sg[i] = 1'b0;
    end
  endtask

  initial begin
    reset     = 1'b1;
    out_ready = 1'b1;
    req_valid = '0; req_data = '0; req_size = '0; req_signed = '0;
    idle_inputs();
    model_reset();
    #1;
    check("init.valid", 64'(out_valid), 64'd0);
    check("init.id",    64'(out_id), 64'd0);
    check("init.ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single requester, byte sign/zero extension.
    v[0] = 1'b1; d[0] = 64'h00000000_000000F0; sz[0] = 2'b00; sg[0] = 1'b1;
    step("t1s");
    check("t1s.const", out_data, 64'hFFFFFFFF_FFFFFFF0);
    sg[0] = 1'b0;
    step("t1z");
    check("t1z.const", out_data, 64'h00000000_000000F0);

    // Size sweep, signed.
    d[0] = 64'hDEADBEEF_87654321; sg[0] = 1'b1;
    sz[0] = 2'b01; step("t2h");
    check("t2h.const", out_data, 64'h00000000_00004321);
    sz[0] = 2'b10; step("t2w");
    check("t2w.const", out_data, 64'hFFFFFFFF_87654321);
    sz[0] = 2'b11; step("t2d");
    check("t2d.const", out_data, 64'hDEADBEEF_87654321);

    // Round-robin from reset: ids 0,1,0,1.
    idle_inputs();
    reset_pulse();
    v[0] = 1'b1; d[0] = 64'h11; v[1] = 1'b1; d[1] = 64'h22; sz[1] = 2'b11;
    for (int i = 0; i < 4; i++) begin
      step("t3");
      check("t3.seq", 64'(out_id), 64'(i % 2));
    end

    // Backpressure: result held three cycles, then drain and accept together.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("t4hold");
    check("t4.heldid", 64'(out_id), 64'd1);
    out_ready = 1'b1;
    step("t4rel");
    check("t4.relid", 64'(out_id), 64'd0);

    // Reset mid-operation with a held result and requests pending.
    out_ready = 1'b0;
    step("t5pre");
    reset_pulse();
    out_ready = 1'b1;
    step("t5post");
    check("t5.first", 64'(out_id), 64'd0);

    // Stall statistic: five stall cycles.
    reset_pulse();
    idle_inputs();
    v[0] = 1'b1; d[0] = 64'h7F;
    step("t6load");
    v[0] = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 5; i++) step("t6stall");
`ifdef EXTEND_ARBITER_STATS_EN
    check("t6.count", 64'(stall_count), 64'd5);
`else
    check("t6.count", 64'(stall_count), 64'd0);
`endif
    out_ready = 1'b1;
    step("t6drain");

    // Random traffic; requesters hold operands until granted.
    idle_inputs();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] || last_gnt[i]) begin
          v[i]  = 1'($urandom_range(0, 1));
          d[i]  = {$urandom, $urandom};
          sz[i] = 2'($urandom_range(0, 3));
          sg[i] = 1'($urandom_range(0, 1));
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
